// File: rtl/mix_sequencer_if.sv
// Host-side bus of the mix sequencer: seed loading, run control, result readback and status.
interface mix_sequencer_if;
  logic        load_valid;
  logic [2:0]  load_idx;
  logic [31:0] load_data;
  logic        start;
  logic        free_run;
  logic [2:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [15:0] runs;

  modport master (
    output load_valid, load_idx, load_data, start, free_run, rd_idx,
    input  rd_data, busy, done, runs
  );

  modport slave (
    input  load_valid, load_idx, load_data, start, free_run, rd_idx,
    output rd_data, busy, done, runs
  );
endinterface

// File: rtl/mix_sequencer.sv
// Eight-register mixing sequencer: one in-order register update per clock through a
// single shared arithmetic unit, with start/busy/done handshake and free-run relaunch.
module mix_sequencer #(
  parameter int unsigned ROUNDS = 12
) (
  input logic            clk,
  input logic            rst,
  mix_sequencer_if.slave bus
);

  localparam logic [5:0] MIX_FIRST  = 6'd5;
  localparam logic [5:0] MUL1_PHASE = 6'(5 + ROUNDS);
  localparam logic [5:0] LAST_PHASE = 6'(6 + ROUNDS);

  localparam logic [7:0][31:0] A1_TAB = {32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3, 32'd2};
  localparam logic [7:0][31:0] B1_TAB = {32'd23, 32'd19, 32'd17, 32'd13, 32'd11, 32'd7, 32'd5, 32'd3};
  localparam logic [7:0][31:0] A2_TAB = {32'd87, 32'd35, 32'd13, 32'd5, 32'd3, 32'd3, 32'd3, 32'd2};
  localparam logic [7:0][31:0] B2_TAB = {32'd343, 32'd216, 32'd125, 32'd64, 32'd27, 32'd8, 32'd1, 32'd0};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  typedef enum logic [2:0] {
    OP_INC, OP_CHAIN, OP_SUB, OP_XOR, OP_SHF, OP_MIX, OP_MUL1, OP_MUL2
  } op_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [5:0]  phase_r;
  logic [2:0]  idx_r;
  logic [31:0] o_r [8];
  logic        busy_r;
  logic        done_r;
  logic [15:0] runs_r;

  op_t         op_s;
  logic        last_s;
  logic [2:0]  idx_p1_s, idx_p2_s, idx_p3_s, idx_p4_s, idx_p5_s, idx_m1_s, idx_m2_s;
  logic [31:0] mul_a_s, mul_b_s, prod_s, upd_s;

  assign idx_p1_s = idx_r + 3'd1;
  assign idx_p2_s = idx_r + 3'd2;
  assign idx_p3_s = idx_r + 3'd3;
  assign idx_p4_s = idx_r + 3'd4;
  assign idx_p5_s = idx_r + 3'd5;
  assign idx_m1_s = idx_r - 3'd1;
  assign idx_m2_s = idx_r - 3'd2;
  assign last_s   = (phase_r == LAST_PHASE) && (idx_r == 3'd7);

  // Map the current phase onto the operation of the shared unit.
  always_comb begin
    op_s = OP_INC;
    if (phase_r < MIX_FIRST) begin
      op_s = op_t'(phase_r[2:0]);
    end else if (phase_r < MUL1_PHASE) begin
      op_s = OP_MIX;
    end else if (phase_r == MUL1_PHASE) begin
      op_s = OP_MUL1;
    end else begin
      op_s = OP_MUL2;
    end
  end

  assign mul_a_s = (op_s == OP_MUL2) ? A2_TAB[idx_r] : A1_TAB[idx_r];
  assign mul_b_s = (op_s == OP_MUL2) ? B2_TAB[idx_r] : B1_TAB[idx_r];
  assign prod_s  = o_r[idx_r] * mul_a_s;

  // Shared add/sub/xor/shift/multiply unit producing the new value of o[i].
  always_comb begin
    upd_s = o_r[idx_r];
    case (op_s)
      OP_INC:   upd_s = o_r[idx_r] + {29'd0, idx_r};
      OP_CHAIN: upd_s = o_r[idx_r] + o_r[idx_m1_s];
      OP_SUB:   upd_s = o_r[idx_r] + o_r[idx_p1_s] - o_r[idx_p5_s];
      OP_XOR:   upd_s = o_r[idx_r] ^ (o_r[idx_p3_s] << 5'd16);
      OP_SHF:   upd_s = o_r[idx_r] - (o_r[idx_p2_s] >> 5'd17) + (o_r[idx_p4_s] >> 5'd12);
      OP_MIX:   upd_s = o_r[idx_r] + o_r[idx_m1_s] - o_r[idx_m2_s];
      OP_MUL1:  upd_s = prod_s + mul_b_s;
      OP_MUL2:  upd_s = prod_s + mul_b_s;
      default:  upd_s = o_r[idx_r];
    endcase
  end

  // Next-state logic: launch on start or free_run, return to idle after the final update.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start || bus.free_run) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Register file, step counter and status; loads only land while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 8; k++) begin
        o_r[k] <= 32'(k);
      end
      phase_r <= 6'd0;
      idx_r   <= 3'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      runs_r  <= 16'd0;
    end else begin
      busy_r <= (state_nxt_s == RUN);
      done_r <= (state_r == RUN) && last_s;
      case (state_r)
        IDLE: begin
          if (bus.load_valid) begin
            o_r[bus.load_idx] <= bus.load_data;
          end
          phase_r <= 6'd0;
          idx_r   <= 3'd0;
        end
        RUN: begin
          o_r[idx_r] <= upd_s;
          idx_r      <= idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            phase_r <= last_s ? 6'd0 : phase_r + 6'd1;
          end
          if (last_s) begin
            runs_r <= runs_r + 16'd1;
          end
        end
        default: begin
          phase_r <= 6'd0;
          idx_r   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.rd_data = o_r[bus.rd_idx];
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.runs    = runs_r;

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed/random bench for mix_sequencer against a schedule-level reference model.
module tb_mix_sequencer;
  localparam int R = 12;
  localparam int N = 8 * (7 + R);

  logic clk = 1'b0;
  logic rst;
  mix_sequencer_if bus ();

  mix_sequencer #(.ROUNDS(R)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #10 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] m [8];
  int unsigned A1 [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  int unsigned B1 [8] = '{3, 5, 7, 11, 13, 17, 19, 23};
  int unsigned A2 [8] = '{2, 3, 3, 3, 5, 13, 35, 87};
  int unsigned B2 [8] = '{0, 1, 8, 27, 64, 125, 216, 343};
  int unsigned EXP16 [8] = '{14, 16, 20, 26, 34, 44, 56, 70};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m[k] = 32'(k);
  endtask

  // Update number s of a run (0-based): phase s/8, register s%8, in-order semantics.
  task automatic model_step(input int s);
    int p;
    int i;
    logic [31:0] x;
    p = s / 8;
    i = s % 8;
    x = m[i];
    if (p == 0)           x = x + 32'(i);
    else if (p == 1)      x = x + m[(i + 7) % 8];
    else if (p == 2)      x = x + m[(i + 1) % 8] - m[(i + 5) % 8];
    else if (p == 3)      x = x ^ (m[(i + 3) % 8] << 16);
    else if (p == 4)      x = x - (m[(i + 2) % 8] >> 17) + (m[(i + 4) % 8] >> 12);
    else if (p < 5 + R)   x = x + m[(i + 7) % 8] - m[(i + 6) % 8];
    else if (p == 5 + R)  x = x * A1[i] + B1[i];
    else                  x = x * A2[i] + B2[i];
    m[i] = x;
  endtask

  task automatic model_run(input int from, input int upto);
    for (int s = from; s < upto; s++) model_step(s);
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 8; k++) begin
      bus.rd_idx = 3'(k);
      #1;
      check($sformatf("%s_o%0d", tag, k), bus.rd_data, m[k]);
    end
  endtask

  task automatic run_to_idle(inout int cnt, inout int ndone);
    while (bus.busy === 1'b1 && cnt < 4 * N) begin
      tick();
      cnt++;
      if (bus.done === 1'b1) ndone++;
    end
  endtask

  int cnt;
  int ndone;
  int cyc;
  int dc [3];
  logic [31:0] seed;

  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_idx   = 3'd0;
    bus.load_data  = 32'd0;
    bus.start      = 1'b0;
    bus.free_run   = 1'b0;
    bus.rd_idx     = 3'd0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    model_reset();
    check_regs("reset");
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_runs", 32'(bus.runs), 32'd0);

    // Single run from reset with intermediate checks
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    cnt = 0;
    ndone = 0;
    while (bus.busy === 1'b1 && cnt < 4 * N) begin
      tick();
      cnt++;
      if (bus.done === 1'b1) ndone++;
      if (cnt == 8) begin
        bus.rd_idx = 3'd7;
        #1;
        check("inc_o7", bus.rd_data, 32'd14);
      end
      if (cnt == 16) begin
        for (int k = 0; k < 8; k++) begin
          bus.rd_idx = 3'(k);
          #1;
          check($sformatf("chain_o%0d", k), bus.rd_data, EXP16[k]);
        end
      end
    end
    check("run1_len", 32'(cnt), 32'(N));
    check("run1_ndone", 32'(ndone), 32'd1);
    check("run1_done_at_end", 32'(bus.done), 32'd1);
    check("run1_runs", 32'(bus.runs), 32'd1);
    model_reset();
    model_run(0, N);
    check_regs("run1");
    tick();
    check("run1_done_pulse_end", 32'(bus.done), 32'd0);

    // Free-run three back-to-back runs from random seeds
    do_reset();
    for (int k = 0; k < 8; k++) begin
      seed = $urandom;
      bus.load_valid = 1'b1;
      bus.load_idx   = 3'(k);
      bus.load_data  = seed;
      m[k] = seed;
      tick();
    end
    bus.load_valid = 1'b0;
    check_regs("seeds");
    bus.free_run = 1'b1;
    tick();
    cyc = 0;
    ndone = 0;
    while (ndone < 3 && cyc < 6 * N) begin
      tick();
      cyc++;
      if (bus.done === 1'b1) begin
        dc[ndone] = cyc;
        ndone++;
      end
      if (ndone == 2 && cyc == dc[1] + 10) bus.free_run = 1'b0;
    end
    bus.free_run = 1'b0;
    check("fr_ndone", 32'(ndone), 32'd3);
    check("fr_first", 32'(dc[0]), 32'(N));
    check("fr_gap1", 32'(dc[1] - dc[0]), 32'(N + 1));
    check("fr_gap2", 32'(dc[2] - dc[1]), 32'(N + 1));
    for (int k = 0; k < 5; k++) tick();
    check("fr_idle_busy", 32'(bus.busy), 32'd0);
    check("fr_runs", 32'(bus.runs), 32'd3);
    for (int r = 0; r < 3; r++) model_run(0, N);
    check_regs("fr");

    // Load and start while busy are ignored
    do_reset();
    model_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cnt = 0;
    ndone = 0;
    while (bus.busy === 1'b1 && cnt < 4 * N) begin
      tick();
      cnt++;
      bus.load_valid = 1'b0;
      bus.start      = 1'b0;
      if (cnt == 40) begin
        bus.load_valid = 1'b1;
        bus.load_idx   = 3'($urandom_range(0, 7));
        bus.load_data  = $urandom;
        bus.start      = 1'b1;
      end
    end
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    check("ign_len", 32'(cnt), 32'(N));
    check("ign_runs", 32'(bus.runs), 32'd1);
    model_run(0, N);
    check_regs("ign");

    // Reset mid-run aborts
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_runs", 32'(bus.runs), 32'd0);
    bus.rd_idx = 3'd5;
    #1;
    check("abort_o5", bus.rd_data, 32'd5);
    model_reset();
    check_regs("abort");
    tick();
    check("abort_stays_idle", 32'(bus.busy), 32'd0);

    // Load together with start; INC wraps o2
    bus.load_valid = 1'b1;
    bus.load_idx   = 3'd2;
    bus.load_data  = 32'hFFFF_FFFF;
    bus.start      = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    bus.start      = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    bus.rd_idx = 3'd2;
    #1;
    check("ldst_o2_wrap", bus.rd_data, 32'h0000_0001);
    model_reset();
    m[2] = 32'hFFFF_FFFF;
    model_run(0, 8);
    check_regs("ldst_inc");
    cnt = 8;
    ndone = 0;
    run_to_idle(cnt, ndone);
    check("ldst_len", 32'(cnt), 32'(N));
    check("ldst_runs", 32'(bus.runs), 32'd1);
    model_run(8, N);
    check_regs("ldst_full");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
